// File: rtl/dino_pkg.sv
// ---------------------------------------------------------------------------
// dino_pkg
//   Shared definitions for the dinosaur jump datapath:
//   - default geometry (ground row, profile length, peak height)
//   - jump FSM state encoding
//   - jump_height(): parabolic height profile used to build the ROM
// ---------------------------------------------------------------------------
package dino_pkg;

    localparam int unsigned DEF_GROUND_Y = 400;
    localparam int unsigned DEF_JUMP_LEN = 51;
    localparam int unsigned DEF_H_MAX    = 100;

    // The profile index is 6 bits wide, so the ROM is padded out to 64 words.
    localparam int unsigned ROM_DEPTH    = 64;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_AIR    = 2'd1,
        ST_LAND   = 2'd2
    } jump_state_e;

    // height[i] = floor(4*h_max*i*(len-1-i) / (len-1)^2); zero outside 0..len-1.
    function automatic logic [6:0] jump_height(input int unsigned i,
                                               input int unsigned len,
                                               input int unsigned h_max);
        int unsigned span;
        int unsigned num;
        span = len - 1;
        if (i >= len || span == 0) begin
            return '0;
        end
        num = 4 * h_max * i * (span - i);
        return 7'(num / (span * span));
    endfunction

endpackage

// File: rtl/jump_profile_rom.sv
// ---------------------------------------------------------------------------
// jump_profile_rom
//   Constant jump-height profile, synchronous read.
//   Ports:
//     clk    in   1  system clock
//     reset  in   1  synchronous active-high; clears the read register
//     en     in   1  read enable; 0 holds the last read word
//     addr   in   6  profile index
//     data   out  7  height in pixels, valid the cycle after addr is sampled
// ---------------------------------------------------------------------------
module jump_profile_rom
    import dino_pkg::*;
#(
    parameter int unsigned JUMP_LEN = DEF_JUMP_LEN,
    parameter int unsigned H_MAX    = DEF_H_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [5:0] addr,
    output logic [6:0] data
);

    logic [6:0] table_w [ROM_DEPTH];

    // Each word is an elaboration-time constant, so this folds into a ROM.
    for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
        localparam logic [6:0] HEIGHT = jump_height(g, JUMP_LEN, H_MAX);
        assign table_w[g] = HEIGHT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (en) begin
            data <= table_w[addr];
        end
    end

endmodule

// File: rtl/jump_height_reader.sv
// ---------------------------------------------------------------------------
// jump_height_reader
//   Converts the jump step address into the sprite top row and jump status.
//   Two-stage pipeline: stage 1 clamps/registers the index and reads the
//   height ROM; stage 2 registers dino_y, the FSM state and status flags.
//   Ports:
//     clk        in   1   system clock
//     reset      in   1   synchronous, active-high
//     gs         in   1   game started; 0 forces the ground state
//     halt       in   1   1 freezes all state and outputs
//     movaddr    in   10  jump step address
//     dino_y     out  10  registered sprite top row
//     airborne   out  1   sprite off the ground
//     jump_done  out  1   one-cycle pulse on entry to the landing entry
//     y_valid    out  1   dino_y reflects the current movaddr
// ---------------------------------------------------------------------------
module jump_height_reader
    import dino_pkg::*;
#(
    parameter int unsigned GROUND_Y = DEF_GROUND_Y,
    parameter int unsigned JUMP_LEN = DEF_JUMP_LEN,
    parameter int unsigned H_MAX    = DEF_H_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gs,
    input  logic       halt,
    input  logic [9:0] movaddr,
    output logic [9:0] dino_y,
    output logic       airborne,
    output logic       jump_done,
    output logic       y_valid
);

    localparam logic [5:0] LAST_IDX   = 6'(JUMP_LEN - 1);
    localparam logic [9:0] LEN_ADDR   = 10'(JUMP_LEN);
    localparam logic [9:0] GROUND_ROW = 10'(GROUND_Y);

    // ---------------- stage 1: clamp, index register, ROM read -------------
    logic [5:0]  idx_c;
    logic [5:0]  idx_q;
    logic [9:0]  mov_q;
    logic        chg_q;
    logic [6:0]  height_q;
    logic        s1_en;

    assign idx_c = (movaddr >= LEN_ADDR) ? LAST_IDX : movaddr[5:0];

    // With gs low the outputs are forced anyway, so stage 1 keeps tracking
    // movaddr; the pipeline is then already primed when gs returns.
    assign s1_en = !halt || !gs;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            mov_q <= '0;
            chg_q <= 1'b0;
        end else if (s1_en) begin
            idx_q <= idx_c;
            mov_q <= movaddr;
            chg_q <= (movaddr != mov_q);
        end
    end

    jump_profile_rom #(
        .JUMP_LEN (JUMP_LEN),
        .H_MAX    (H_MAX)
    ) u_rom (
        .clk   (clk),
        .reset (reset),
        .en    (s1_en),
        .addr  (idx_c),
        .data  (height_q)
    );

    // ---------------- stage 2: FSM and output registers --------------------
    jump_state_e state_q;
    jump_state_e state_n;
    logic [9:0]  dino_y_n;
    logic        airborne_n;
    logic        jump_done_n;
    logic        gs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_GROUND;
            dino_y    <= GROUND_ROW;
            airborne  <= 1'b0;
            jump_done <= 1'b0;
            gs_q      <= 1'b1;
        end else begin
            state_q   <= state_n;
            dino_y    <= dino_y_n;
            airborne  <= airborne_n;
            jump_done <= jump_done_n;
            gs_q      <= gs;
        end
    end

    // State follows the registered index directly; jump_done is the edge into
    // LAND. While halted nothing advances, so a pending landing pulse simply
    // fires on the first unhalted edge.
    always_comb begin
        state_n     = state_q;
        dino_y_n    = dino_y;
        airborne_n  = airborne;
        jump_done_n = jump_done;

        if (!gs) begin
            state_n     = ST_GROUND;
            dino_y_n    = GROUND_ROW;
            airborne_n  = 1'b0;
            jump_done_n = 1'b0;
        end else if (!halt) begin
            if (idx_q == '0) begin
                state_n = ST_GROUND;
            end else if (idx_q == LAST_IDX) begin
                state_n = ST_LAND;
            end else begin
                state_n = ST_AIR;
            end
            dino_y_n    = GROUND_ROW - {3'b000, height_q};
            airborne_n  = (state_n == ST_AIR);
            jump_done_n = (state_n == ST_LAND) && (state_q != ST_LAND);
        end
    end

    // Stale while movaddr differs from the sampled copy (cycle before stage 1
    // catches it), while stage 2 is still catching up (chg_q), and for the
    // first cycle after gs returns.
    assign y_valid = !gs || ((movaddr == mov_q) && !chg_q && gs_q);

endmodule

// File: tb/tb_jump_height_reader.sv
// ---------------------------------------------------------------------------
// tb_jump_height_reader
//   Scoreboard bench: each address step pushes its expected result; the
//   monitor pops and compares whenever y_valid rises (a new result appears).
// ---------------------------------------------------------------------------
module tb_jump_height_reader;

    localparam int GY = 400;
    localparam int JL = 51;
    localparam int HM = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       gs = 1'b1;
    logic       halt = 1'b0;
    logic [9:0] movaddr = '0;
    logic [9:0] dino_y;
    logic       airborne;
    logic       jump_done;
    logic       y_valid;

    always #5 clk = ~clk;

    jump_height_reader #(
        .GROUND_Y (GY),
        .JUMP_LEN (JL),
        .H_MAX    (HM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .gs        (gs),
        .halt      (halt),
        .movaddr   (movaddr),
        .dino_y    (dino_y),
        .airborne  (airborne),
        .jump_done (jump_done),
        .y_valid   (y_valid)
    );

    typedef struct {
        int y;
        int air;
        int jd;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   pulse_cnt = 0;
    int   prev_i = 0;
    int   prev_y = GY;
    logic prev_valid = 1'b1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp_idx(input int a);
        return (a >= JL) ? JL - 1 : a;
    endfunction

    function automatic int exp_y(input int i);
        return GY - (4 * HM * i * (JL - 1 - i)) / ((JL - 1) * (JL - 1));
    endfunction

    function automatic exp_t make_exp(input int a, input int last_i);
        exp_t e;
        int   i;
        i     = clamp_idx(a);
        e.y   = exp_y(i);
        e.air = (i > 0 && i < JL - 1) ? 1 : 0;
        e.jd  = (i == JL - 1 && last_i != JL - 1) ? 1 : 0;
        return e;
    endfunction

    // Monitor: count jump_done high cycles; compare on every y_valid rise.
    always @(negedge clk) begin
        exp_t e;
        if (jump_done === 1'b1) pulse_cnt++;
        if (!reset && gs && y_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_output", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check_val("sb_dino_y", int'(dino_y), e.y);
                check_val("sb_airborne", int'(airborne), e.air);
                check_val("sb_jump_done", int'(jump_done), e.jd);
            end
        end
        prev_valid = y_valid;
    end

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check_val("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    // Drive one address change and check the two-edge latency directly.
    task automatic step(input int a);
        exp_t e;
        e = make_exp(a, prev_i);
        sb_q.push_back(e);
        @(negedge clk);
        #1 movaddr = 10'(a);
        @(negedge clk);
        check_val("lat_valid_low", int'(y_valid), 0);
        check_val("lat_hold_y", int'(dino_y), prev_y);
        @(negedge clk);
        check_val("lat_new_y", int'(dino_y), e.y);
        check_val("lat_valid_high", int'(y_valid), 1);
        prev_i = clamp_idx(a);
        prev_y = e.y;
        drain(4);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int   p0;
        exp_t e;

        // Reset
        repeat (3) @(negedge clk);
        check_val("rst_dino_y", int'(dino_y), GY);
        check_val("rst_airborne", int'(airborne), 0);
        check_val("rst_jump_done", int'(jump_done), 0);
        check_val("rst_y_valid", int'(y_valid), 1);
        #1 reset = 1'b0;

        // Idle on the ground
        repeat (6) @(negedge clk);
        check_val("idle_dino_y", int'(dino_y), GY);
        check_val("idle_pulses", pulse_cnt, 0);

        // Spot values
        step(10);
        check_val("y_at_10", int'(dino_y), 336);
        check_val("air_at_10", int'(airborne), 1);
        step(25);
        check_val("y_at_25", int'(dino_y), 300);

        // Full sweep: exactly one landing pulse
        p0 = pulse_cnt;
        for (int a = 1; a <= 50; a++) step(a);
        @(negedge clk);
        #1;
        check_val("sweep_pulses", pulse_cnt - p0, 1);
        check_val("y_at_50", int'(dino_y), 400);
        check_val("air_at_50", int'(airborne), 0);
        step(0);
        repeat (3) @(negedge clk);
        check_val("ground_no_2nd_pulse", pulse_cnt - p0, 1);

        // Out-of-range address clamps to the landing entry
        p0 = pulse_cnt;
        step(700);
        check_val("y_at_700", int'(dino_y), 400);
        @(negedge clk);
        #1;
        check_val("clamp_pulses", pulse_cnt - p0, 1);

        // Restart from LAND without passing through 0: no pulse
        p0 = pulse_cnt;
        step(10);
        check_val("restart_air", int'(airborne), 1);
        repeat (3) @(negedge clk);
        check_val("restart_pulses", pulse_cnt - p0, 0);
        step(0);

        // Halt with a simultaneous address change
        step(25);
        e = make_exp(26, prev_i);
        sb_q.push_back(e);
        @(negedge clk);
        #1 begin halt = 1'b1; movaddr = 10'd26; end
        repeat (4) @(negedge clk);
        check_val("halt_frozen_y", int'(dino_y), 300);
        check_val("halt_y_valid", int'(y_valid), 0);
        check_val("halt_sb_pending", sb_q.size(), 1);
        #1 halt = 1'b0;
        @(negedge clk);
        check_val("halt_rel_hold", int'(dino_y), 300);
        @(negedge clk);
        check_val("halt_rel_y", int'(dino_y), 301);
        prev_i = 26;
        prev_y = 301;
        drain(4);

        // Landing pulse deferred by halt arriving between the two stages
        step(49);
        e = make_exp(50, prev_i);
        sb_q.push_back(e);
        @(negedge clk);
        #1 movaddr = 10'd50;
        @(negedge clk);
        #1 halt = 1'b1;
        p0 = pulse_cnt;
        repeat (3) @(negedge clk);
        check_val("defer_jd_low", int'(jump_done), 0);
        check_val("defer_y_frozen", int'(dino_y), exp_y(49));
        check_val("defer_no_pulse", pulse_cnt - p0, 0);
        #1 halt = 1'b0;
        drain(4);
        @(negedge clk);
        #1;
        check_val("defer_pulse", pulse_cnt - p0, 1);
        prev_i = 50;
        prev_y = 400;
        step(0);

        // Reset mid-jump
        step(25);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_val("midrst_dino_y", int'(dino_y), GY);
        check_val("midrst_airborne", int'(airborne), 0);
        check_val("midrst_jump_done", int'(jump_done), 0);
        e = make_exp(0, 0);
        sb_q.push_back(e);
        #1 begin reset = 1'b0; movaddr = '0; end
        prev_i = 0;
        prev_y = GY;
        drain(4);

        // gs falling mid-jump
        step(25);
        @(negedge clk);
        #1 gs = 1'b0;
        @(negedge clk);
        check_val("gs0_dino_y", int'(dino_y), GY);
        check_val("gs0_airborne", int'(airborne), 0);
        check_val("gs0_jump_done", int'(jump_done), 0);
        check_val("gs0_y_valid", int'(y_valid), 1);
        #1 gs = 1'b1;
        #1 check_val("gs1_stale", int'(y_valid), 0);
        @(negedge clk);
        check_val("gs1_dino_y", int'(dino_y), 300);
        check_val("gs1_airborne", int'(airborne), 1);
        check_val("gs1_y_valid", int'(y_valid), 1);
        prev_i = 25;
        prev_y = 300;
        step(0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
